// File: rtl/updown_count_monitor.sv
// rtl/updown_count_monitor.sv - step/wrap checker for an N-bit up/down counter
// Optional q_min/q_max tracking is enabled by defining UDMON_MINMAX_EN.
module updown_count_monitor #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  q,
    input  logic          mod,
    input  logic          clr,
    output logic          wrap_pulse,
    output logic          wrap_up,
    output logic [CW-1:0] wrap_cnt,
    output logic          step_err,
    output logic [N-1:0]  err_q,
    output logic [N-1:0]  err_exp,
    output logic          tracking,
    output logic [N-1:0]  q_min,
    output logic [N-1:0]  q_max
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    logic [1:0]   state;
    logic [N-1:0] q_d;
    logic         m_d;
    logic [N-1:0] exp_q;
    logic         legal_step;

    assign exp_q      = m_d ? q_d + N'(1) : q_d - N'(1);
    assign legal_step = (state == ST_TRACK) && (q == exp_q);
    assign tracking   = (state == ST_TRACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            q_d        <= '0;
            m_d        <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            err_q      <= '0;
            err_exp    <= '0;
        end else if (clr) begin
            // wrap_up deliberately survives clr so the last direction stays visible
            state      <= ST_INIT;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            err_q      <= '0;
            err_exp    <= '0;
        end else begin
            wrap_pulse <= 1'b0;
            case (state)
                ST_INIT: begin
                    q_d   <= q;
                    m_d   <= mod;
                    state <= ST_TRACK;
                end
                ST_TRACK: begin
                    q_d <= q;
                    m_d <= mod;
                    if (q == exp_q) begin
                        if ((m_d && (q_d == '1)) || (!m_d && (q_d == '0))) begin
                            wrap_pulse <= 1'b1;
                            wrap_up    <= m_d;
                            if (wrap_cnt != '1)
                                wrap_cnt <= wrap_cnt + CW'(1);
                        end
                    end else begin
                        step_err <= 1'b1;
                        err_q    <= q;
                        err_exp  <= exp_q;
                        state    <= ST_ERROR;
                    end
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

`ifdef UDMON_MINMAX_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_min <= '1;
            q_max <= '0;
        end else if (state == ST_INIT) begin
            q_min <= q;
            q_max <= q;
        end else if (legal_step) begin
            if (q < q_min) q_min <= q;
            if (q > q_max) q_max <= q;
        end
    end
`else
    assign q_min = '0;
    assign q_max = '0;
`endif

endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
- Downstream checker/event stage for the N-bit up/down counter; samples the counter's q and mod every clock.
- Verifies each step is exactly ±1 (mod 2^N) in the commanded direction and flags wrap-around events with direction.
- Keeps a saturating wrap count and captures the first illegal step for debug.
- Sits beside the counter on the same clk/rst and feeds status/interrupt logic.

Parameters:
- N, 4, counter width; width of q, err_q, err_exp.
- CW, 8, width of wrap_cnt.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- q  input  N  counter output being monitored
- mod  input  1  counter direction command: 1 = up, 0 = down
- clr  input  1  synchronous clear of error/capture state and wrap_cnt; no effect while rst=1
- wrap_pulse  output  1  one-cycle pulse on a legal wrap step
- wrap_up  output  1  direction of the last wrap: 1 = max->0, 0 = 0->max
- wrap_cnt  output  CW  number of wraps since reset/clr; saturates at all-ones
- step_err  output  1  sticky: an illegal step was detected
- err_q  output  N  q value of the first illegal step
- err_exp  output  N  expected q at the first illegal step
- tracking  output  1  high in TRACK state

Behaviour:
- Reset: one clock; reset is synchronous and active-high. All registers cleared while rst=1 at a clock edge: state=INIT, all outputs 0, q_d=0, m_d=0.
- Internal regs: q_d, m_d capture q and mod at every edge in INIT and TRACK.
- Step model: at edge k the counter moves to q(k) using the mod seen at edge k. The monitor checks wire q against exp = m_d ? q_d+1 : q_d-1, with arithmetic modulo 2^N.
- FSM states: INIT, TRACK, ERROR.
- INIT: first edge with rst=0 captures q/mod and moves to TRACK. No check this edge; tracking=0.
- TRACK, q==exp:
  - Legal step; stay in TRACK.
  - If m_d=1 and q_d=2^N-1 (so q=0): wrap_pulse=1, wrap_up=1, wrap_cnt++.
  - If m_d=0 and q_d=0 (so q=2^N-1): wrap_pulse=1, wrap_up=0, wrap_cnt++.
- TRACK, q!=exp (including hold, or a jump of any size):
  - step_err<=1, err_q<=q, err_exp<=exp; go to ERROR.
  - wrap_pulse=0 on that edge.
- ERROR: no checking, no wrap counting; q_d/m_d frozen; outputs hold. Exit only via clr or rst.
- Output timing: all outputs are registered and update at the same edge where the step is evaluated, i.e. one cycle after q changes. wrap_pulse is high for exactly that cycle.
- Direction changes: a mod toggle is legal. The next step follows the new mod, with no error and no extra latency.
- clr=1 (rst=0): step_err, err_q, err_exp, wrap_cnt, wrap_pulse <= 0; state <= INIT; wrap_up unchanged.
- rst has priority over clr.
- Saturation: when wrap_cnt is all-ones, a further wrap still pulses wrap_pulse and updates wrap_up; wrap_cnt holds.
- rst asserted mid-operation: everything returns to reset values at that edge. A counter restart at 0 is not an error.

Optional Feature:
- Macro: UDMON_MINMAX_EN.
- Defined: adds outputs q_min and q_max (N bits each).
  - Both are loaded with q on the INIT capture edge.
  - They update on each legal TRACK step.
  - Reset/clr value: q_min=all-ones, q_max=0.
  - Frozen in ERROR.
- Undefined: the q_min/q_max ports remain but are tied to 0, with no extra registers.

Test Plan:
- N=4, rst 1->0 with the counter running and mod=1 from q=0 for 17 steps:
  - tracking=1 after the first edge.
  - wrap_pulse once, at the step 15->0; wrap_up=1, wrap_cnt=1, step_err=0.
- After reset, mod=0 from q=0:
  - first step 0->15 gives wrap_pulse=1, wrap_up=0, wrap_cnt=1.
  - next step 15->14 gives no pulse.
- Force q sequence 4,5,7 with mod=1:
  - step_err=1, err_q=7, err_exp=6, state ERROR.
  - a later 15->0 step gives no wrap_pulse.
  - clr for one cycle clears the error; a legal run then resumes checking.
- Force q sequence 3,4,3 with mod toggled 1->0 at the 4:
  - no step_err, no wrap_pulse.
  - with UDMON_MINMAX_EN: q_min=3, q_max=4.
- CW=2, 5 up-wraps:
  - wrap_cnt reads 1,2,3,3,3.
  - wrap_pulse occurs on all 5 wraps.
- rst mid-run with wrap_cnt=2 and step_err=1:
  - all outputs 0 at the reset edge.
  - the counter restarting from 0 produces no error.
